sm2_fast_reduce: RTL and testbench

Iterative modular reducer that consumes the 512-bit products emitted by the Karatsuba multiplier and returns the 256-bit residue modulo the SM2 prime p = 2^256 − 2^224 − 2^96 + 2^64 − 1 (FFFFFFFE FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF 00000000 FFFFFFFF FFFFFFFF). It sits between the multiplier output and the field-arithmetic register file in the SM2 datapath. It uses a valid/ready handshake on both sides and holds one operand at a time.

---
 rtl/sm2_fast_reduce.sv | 172 +++++++++++++++++
 tb/tb_sm2_fast_reduce.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm2_fast_reduce.sv
// sm2_fast_reduce
//   Iterative reducer of a 512-bit product modulo the SM2 prime
//   p = 2^256 - 2^224 - 2^96 + 2^64 - 1. It holds one operand at a time.
//   The operand is folded using 2^256 == 2^224 + 2^96 - 2^64 + 1 (mod p)
//   until it fits in 256 bits. A single conditional subtraction of p then
//   gives the fully reduced result.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data is valid
//   in_ready   out  block can accept (IDLE only)
//   in_data    in   512-bit product to reduce
//   out_valid  out  out_data holds the result (DONE)
//   out_ready  in   consumer accepts the result
//   out_data   out  in_data mod p, in [0, p-1]
//   busy       out  high in FOLD, SUB and DONE
//
// Configuration macro
//   SM2_RED_FIXED_LAT_EN : when defined, always run exactly MAX_FOLD folds and
//   always compute acc - p. Latency is then MAX_FOLD+1 edges for every operand.
//   When undefined, folding stops as soon as the upper half is zero.

module sm2_fast_reduce #(
  parameter int MAX_FOLD = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_data,
  output logic         busy
);

  localparam logic [255:0] P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [3:0] LAST_FOLD = 4'(MAX_FOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [512:0] acc;
  logic [3:0]   fcnt;

  // ---------------------------------------------------------------------------
  // Fold datapath: acc <- l + h*2^224 + h*2^96 - h*2^64 + h.
  // The adder is 514 bits wide so that no intermediate term wraps. The
  // subtraction cannot make the total negative, because h*2^96 >= h*2^64.
  // ---------------------------------------------------------------------------
  logic [256:0] fold_h;
  logic [255:0] fold_l;
  logic [513:0] h_ext;
  logic [513:0] fold_sum;
  logic         fold_last;

  assign fold_h    = acc[512:256];
  assign fold_l    = acc[255:0];
  assign h_ext     = {257'd0, fold_h};
  assign fold_sum  = {258'd0, fold_l} + (h_ext << 224) + (h_ext << 96)
                   - (h_ext << 64) + h_ext;
  assign fold_last = (fcnt == LAST_FOLD);

`ifndef SM2_RED_FIXED_LAT_EN
  logic fold_clear;
  assign fold_clear = (fold_sum[513:256] == '0);
`endif

  // ---------------------------------------------------------------------------
  // Final conditional subtraction. After folding, acc < 2^256 < 2p, so a
  // single subtraction of p is enough.
  // ---------------------------------------------------------------------------
  logic [255:0] sub_result;

`ifdef SM2_RED_FIXED_LAT_EN
  // Always form the difference. The borrow out picks the result through a mux,
  // so the same logic toggles whatever the operand value.
  logic [256:0] sub_diff;
  assign sub_diff   = {1'b0, fold_l} - {1'b0, P};
  assign sub_result = sub_diff[256] ? fold_l : sub_diff[255:0];
`else
  assign sub_result = (fold_l >= P) ? (fold_l - P) : fold_l;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef SM2_RED_FIXED_LAT_EN
          state_next = FOLD;
`else
          state_next = (in_data[511:256] != '0) ? FOLD : SUB;
`endif
        end
      end
      FOLD: begin
`ifdef SM2_RED_FIXED_LAT_EN
        if (fold_last) state_next = SUB;
`else
        // fold_last only bounds the loop. Any 512-bit operand clears
        // within MAX_FOLD folds.
        if (fold_clear || fold_last) state_next = SUB;
`endif
      end
      SUB:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      fcnt     <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc  <= {1'b0, in_data};
            fcnt <= '0;
          end
        end
        FOLD: begin
          acc  <= fold_sum[512:0];
          fcnt <= fcnt + 4'd1;
        end
        SUB: begin
          out_data <= sub_result;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm2_fast_reduce.sv
// Scoreboard bench for sm2_fast_reduce.
// When an operand is accepted, the bench pushes the expected residue and the
// accept edge into queues. On each new result, a negedge monitor pops them and
// checks the data and the latency. The expected residues come from a
// bit-serial shift/subtract reduction, which does not use the fold identity.
module tb_sm2_fast_reduce;

  localparam int MAX_FOLD = 10;
  localparam logic [255:0] P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic         busy;

  sm2_fast_reduce #(.MAX_FOLD(MAX_FOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] got,
                          input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit-serial reference: r = (2r + bit) mod p, most significant bit first.
  function automatic logic [255:0] ref_mod(input logic [511:0] x);
    logic [256:0] r;
    r = '0;
    for (int i = 511; i >= 0; i--) begin
      r = {r[255:0], x[i]};
      if (r >= {1'b0, P}) r = r - {1'b0, P};
    end
    return r[255:0];
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Scoreboard queues
  logic [255:0] exp_q[$];
  int           e0_q[$];
  bit           small_q[$];

  // Monitor: checks each result on the first cycle that out_valid is high
  bit seen = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", 256'(out_valid), 256'(0));
      end else begin
        logic [255:0] e;
        int e0, lat;
        bit sm;
        e   = exp_q.pop_front();
        e0  = e0_q.pop_front();
        sm  = small_q.pop_front();
        lat = ecnt - e0;
        check_eq("data", out_data, e);
`ifdef SM2_RED_FIXED_LAT_EN
        check_eq("latency_fixed", 256'(lat), 256'(MAX_FOLD + 1));
`else
        if (sm) check_eq("latency_small", 256'(lat), 256'(1));
        else    check_eq("latency_bound", 256'(lat >= 2 && lat <= MAX_FOLD + 1),
                         256'(1));
`endif
      end
    end else if (!out_valid) begin
      seen = 1'b0;
    end
  end

  task automatic send_exp(input logic [511:0] d, input logic [255:0] e);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 256'(in_ready), 256'(1));
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    e0_q.push_back(ecnt + 1);
    small_q.push_back(d[511:256] == '0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand512();  // only the accepting edge samples in_data
  endtask

  task automatic send(input logic [511:0] d);
    send_exp(d, ref_mod(d));
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || busy) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check_eq("drain", 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    logic [511:0] pm1_sq;
    logic [511:0] d;
    logic [255:0] held;
    int waited;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready",  256'(in_ready),  256'(1));
    check_eq("rst_out_valid", 256'(out_valid), 256'(0));
    check_eq("rst_out_data",  out_data,        256'(0));
    check_eq("rst_busy",      256'(busy),      256'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed boundary operands
    pm1_sq = {256'd0, P - 256'd1} * {256'd0, P - 256'd1};
    send_exp(512'd0, 256'd0);
    send_exp({256'd0, P}, 256'd0);
    send_exp({256'd0, P - 256'd1}, P - 256'd1);
    send_exp(pm1_sq, 256'd1);
    send({512{1'b1}});
    send({255'd0, 1'b1, 256'd0});          // 2^256
    send({256'd0, {256{1'b1}}});           // 2^256 - 1
    send({256'd1, P});                     // 2^256 + p
    drain();

    // Random operands, with a mix of operand sizes
    for (int i = 0; i < 2000; i++) begin
      d = rand512();
      if (i % 4 == 1) d = d >> $urandom_range(0, 511);
      if (i % 4 == 2) d = d >> $urandom_range(200, 300);
      send(d);
    end
    drain();

    // Back-pressure: hold the result with out_ready low
    out_ready = 1'b0;
    send(rand512());
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("hold_valid_seen", 256'(out_valid), 256'(1));
    held = out_data;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_eq("hold_data",     out_data,          held);
      check_eq("hold_in_ready", 256'(in_ready),    256'(0));
      check_eq("hold_busy",     256'(busy),        256'(1));
      check_eq("hold_valid",    256'(out_valid),   256'(1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("release_in_ready",  256'(in_ready),  256'(1));
    check_eq("release_out_valid", 256'(out_valid), 256'(0));

    // Asynchronous reset while folding
    send({512{1'b1}});
    @(negedge clk);
    check_eq("pre_rst_busy", 256'(busy), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 256'(out_valid), 256'(0));
    check_eq("midrst_in_ready",  256'(in_ready),  256'(1));
    check_eq("midrst_busy",      256'(busy),      256'(0));
    exp_q.delete();
    e0_q.delete();
    small_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_exp(512'd5, 256'd5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
